// File: rtl/mig_write_coalescer_if.sv
// rtl/mig_write_coalescer_if.sv - pixel-in / MIG-request-out bundle for the write coalescer
interface mig_write_coalescer_if #(
    parameter int HRES   = 320,
    parameter int VRES   = 180,
    parameter int PIX_W  = 16,
    parameter int WORDS  = 8,
    parameter int ADDR_W = 27
);
    localparam int BYTES = WORDS * PIX_W / 8;

    logic [$clog2(HRES)-1:0] hcount_in;
    logic [$clog2(VRES)-1:0] vcount_in;
    logic [PIX_W-1:0]        color_in;
    logic                    mask_zero_in;
    logic                    frame_in;
    logic                    valid_in;
    logic                    rdy_out;
    logic                    flush_in;
    logic [ADDR_W-1:0]       addr_out;
    logic [WORDS*PIX_W-1:0]  data_out;
    logic [BYTES-1:0]        strobe_out;
    logic                    valid_out;
    logic                    rdy_in;
    logic                    busy_out;

    modport slave (
        input  hcount_in, vcount_in, color_in, mask_zero_in, frame_in, valid_in, flush_in, rdy_in,
        output rdy_out, addr_out, data_out, strobe_out, valid_out, busy_out
    );

    modport master (
        output hcount_in, vcount_in, color_in, mask_zero_in, frame_in, valid_in, flush_in, rdy_in,
        input  rdy_out, addr_out, data_out, strobe_out, valid_out, busy_out
    );
endinterface

// File: rtl/mig_write_coalescer.sv
// rtl/mig_write_coalescer.sv - packs pixel writes into strobed full-width MIG write requests
module mig_write_coalescer #(
    parameter int HRES    = 320,
    parameter int VRES    = 180,
    parameter int PIX_W   = 16,
    parameter int WORDS   = 8,
    parameter int ADDR_W  = 27,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    mig_write_coalescer_if.slave   bus
);
    localparam int BYTES  = WORDS * PIX_W / 8;
    localparam int PB     = PIX_W / 8;
    localparam int LANE_W = $clog2(WORDS);
    localparam int BOFF_W = $clog2(BYTES);
    localparam int LINE_W = $clog2((HRES * VRES + WORDS - 1) / WORDS);
    localparam int FB     = LINE_W + BOFF_W;
    localparam int H_W    = $clog2(HRES);
    localparam int V_W    = $clog2(VRES);
    // Wide enough for any hcount/vcount code, so out-of-range pixels never alias by truncation
    localparam int P_W    = H_W + V_W + 1;
    localparam int TAG_W  = P_W - LANE_W;
    localparam int TMO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {S_EMPTY, S_ACCUM} state_t;

    state_t                 state, state_nxt;
    logic [TAG_W-1:0]       acc_line;
    logic                   acc_frame;
    logic [WORDS*PIX_W-1:0] acc_data;
    logic [BYTES-1:0]       acc_strb;
    logic                   flush_pend, flush_pend_nxt;
    logic [TMO_W-1:0]       tmo_cnt, tmo_nxt;

    logic                   valid_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [WORDS*PIX_W-1:0] data_q;
    logic [BYTES-1:0]       strb_q;

    logic [P_W-1:0]         pix_idx;
    logic [TAG_W-1:0]       pix_line;
    logic [LANE_W-1:0]      pix_lane;
    logic                   slot_free, accept, same, diff, lane_last, tmo_hit, drain;

    logic [WORDS*PIX_W-1:0] wr_data, emit_data;
    logic [BYTES-1:0]       wr_strb, emit_strb;
    logic [TAG_W-1:0]       emit_line;
    logic                   emit_frame, emit, acc_we, wrap;
    logic [ADDR_W-1:0]      emit_addr;

    assign pix_idx   = P_W'(bus.hcount_in) + P_W'(HRES) * P_W'(bus.vcount_in);
    assign pix_lane  = pix_idx[LANE_W-1:0];
    assign pix_line  = pix_idx[P_W-1:LANE_W];
    assign lane_last = (pix_lane == LANE_W'(WORDS - 1));
    assign slot_free = !valid_q || bus.rdy_in;
    assign accept    = bus.valid_in && slot_free && !flush_pend;
    assign same      = (state == S_ACCUM) && (pix_line == acc_line) && (bus.frame_in == acc_frame);
    assign diff      = (state == S_ACCUM) && !same;
    assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt == TMO_W'(TIMEOUT));
    // Idle emit of the accumulator: explicit/wrap flush or timeout, only into a free slot
    assign drain     = !accept && (state == S_ACCUM) && slot_free && (flush_pend || tmo_hit);

    assign bus.rdy_out    = slot_free && !flush_pend;
    assign bus.valid_out  = valid_q;
    assign bus.addr_out   = addr_q;
    assign bus.data_out   = data_q;
    assign bus.strobe_out = strb_q;
    assign bus.busy_out   = (state == S_ACCUM) || valid_q || flush_pend;

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= S_EMPTY;
        else        state <= state_nxt;
    end

    // Next state: a finishing lane closes the line unless a different line is being evicted
    always_comb begin
        state_nxt = state;
        if (accept)     state_nxt = (lane_last && !diff) ? S_EMPTY : S_ACCUM;
        else if (drain) state_nxt = S_EMPTY;
    end

    // Output/datapath controls: lane merge, emission source select, flush and timeout bookkeeping
    always_comb begin
        wr_data = same ? acc_data : '0;
        wr_strb = same ? acc_strb : '0;
        for (int k = 0; k < WORDS; k++) begin
            if (pix_lane == LANE_W'(k)) begin
                wr_data[k*PIX_W +: PIX_W] = bus.color_in;
                wr_strb[k*PB +: PB]       = {PB{!bus.mask_zero_in}};
            end
        end
        emit       = drain;
        emit_line  = acc_line;
        emit_frame = acc_frame;
        emit_data  = acc_data;
        emit_strb  = acc_strb;
        acc_we     = accept;
        wrap       = 1'b0;
        if (accept) begin
            if (diff) begin
                // Old line goes out now; a new line that is already complete is flushed next
                emit = 1'b1;
                wrap = lane_last;
            end else if (lane_last) begin
                emit       = 1'b1;
                emit_line  = pix_line;
                emit_frame = bus.frame_in;
                emit_data  = wr_data;
                emit_strb  = wr_strb;
            end
        end
        emit_addr = (ADDR_W'(emit_frame) << FB) | (ADDR_W'(emit_line[LINE_W-1:0]) << BOFF_W);
        flush_pend_nxt = (state_nxt == S_ACCUM) && (flush_pend || bus.flush_in || wrap);
        if (accept || emit || state_nxt == S_EMPTY || TIMEOUT == 0) tmo_nxt = '0;
        else if (!tmo_hit)                                          tmo_nxt = tmo_cnt + 1'b1;
        else                                                        tmo_nxt = tmo_cnt;
    end

    // Accumulator contents, flush flag and idle counter
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc_line   <= '0;
            acc_frame  <= 1'b0;
            acc_data   <= '0;
            acc_strb   <= '0;
            flush_pend <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            if (acc_we) begin
                acc_line  <= pix_line;
                acc_frame <= bus.frame_in;
                acc_data  <= wr_data;
                acc_strb  <= wr_strb;
            end
            flush_pend <= flush_pend_nxt;
            tmo_cnt    <= tmo_nxt;
        end
    end

    // Output register: load on a non-empty emit, hold while stalled, drop after handshake
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else if (emit && |emit_strb) begin
            valid_q <= 1'b1;
            addr_q  <= emit_addr;
            data_q  <= emit_data;
            strb_q  <= emit_strb;
        end else if (bus.rdy_in) begin
            valid_q <= 1'b0;
        end
    end
endmodule
